cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Producer end of the common data bus (CDB) that the reservation station snoops for wakeup.
- Accepts completed results from NUM_FU execution units over a valid/ready handshake and buffers each source in a small FIFO.
- Each cycle, grants up to CDB_W sources by round-robin and broadcasts their tag, value and ROB tag on registered CDB outputs.

Parameters:
- NUM_FU, 4, number of execution-unit result sources
- CDB_W, 2, CDB broadcast slots per cycle
- PHYS_W, 6, physical register tag width
- FIFO_DEPTH, 2, per-source result buffer depth (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush; discards all buffered and pending results
- fu_valid  in  NUM_FU  source i presents a result
- fu_ready  out  NUM_FU  source i FIFO can accept
- fu_tag  in  NUM_FU x PHYS_W  destination physical tag
- fu_value  in  NUM_FU x 64  result value
- fu_rob_tag  in  NUM_FU x 6  ROB index
- cdb_valid  out  CDB_W  slot carries a broadcast this cycle
- cdb_tag  out  CDB_W x PHYS_W  broadcast tag
- cdb_value  out  CDB_W x 64  broadcast value
- cdb_rob_tag  out  CDB_W x 6  broadcast ROB index
- busy  out  1  any FIFO non-empty or any cdb_valid set

Behaviour:
- Reset (reset=0, asynchronous):
  - all FIFOs empty; rr pointer = 0
  - cdb_valid = 0; cdb_tag, cdb_value, cdb_rob_tag = 0
  - fu_ready = all 1 once reset deasserts; busy = 0
- Accept:
  - fu_ready[i] = !full[i] (count < FIFO_DEPTH), combinational from registered count only.
  - fu_ready does not depend on fu_valid or on same-cycle pops; a full FIFO stays not-ready for the cycle even if it pops.
  - Push on fu_valid[i] & fu_ready[i] at the rising edge.
  - fu_valid without fu_ready: no push; the source must hold its data.
- Select (combinational, each cycle):
  - Scan sources starting at rr, wrapping modulo NUM_FU.
  - The first CDB_W non-empty FIFOs are granted.
  - The k-th granted source in scan order drives slot k.
  - Each source is granted at most once per cycle.
- Broadcast:
  - Granted FIFO heads pop at the edge; the same edge registers them onto cdb_* outputs.
  - Ungranted slots: cdb_valid[k] = 0 and data fields = 0.
  - Latency: a result pushed at edge N broadcasts in the cycle following edge N+1 at the earliest (2 edges). No bypass.
- Round-robin:
  - If at least one grant: rr <= (index of last granted source + 1) mod NUM_FU.
  - No grants: rr unchanged.
  - Guarantee: no non-empty source waits more than ceil(NUM_FU/CDB_W) select cycles.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved (FIFO pointers wrap modulo FIFO_DEPTH).
- Flush:
  - At the edge: all FIFOs cleared, cdb_valid <= 0, pushes that cycle ignored, rr <= 0.
  - fu_ready is unaffected combinationally.
  - Flush overrides all other actions.
- Duplicate tags across slots are passed through unchanged; tag uniqueness is the rename stage's responsibility.
- Widths: counts are clog2(FIFO_DEPTH)+1 bits; no arithmetic on data fields.

Test Plan:
- Single result: after reset, FU0 pushes tag=10, value=8, rob=0 at edge 1 -> cdb_valid=01, cdb_tag[0]=10, cdb_value[0]=8 in the cycle after edge 2; busy=0 after edge 3.
- Fairness, all four FUs push every cycle (tags 20..23), rr=0:
  - first broadcast slots carry 20,21; next 22,23; then 20,21.
  - No FU is starved over 8 cycles; every accepted tag appears exactly once, in per-FU order.
- Backpressure:
  - FU1 pushes 3 back-to-back with only FU0..FU3 contending: fu_ready[1]=0 when count=2.
  - Third value held by the source is accepted only after a pop; values broadcast in push order 5,6,7.
- Flush mid-stream:
  - With 2 results in FU2 FIFO and cdb_valid=11, assert flush one cycle.
  - Next cycle cdb_valid=00, busy=0, no flushed tag ever broadcasts.
  - The push attempted in the flush cycle is dropped.
- Reset mid-operation: deassert reset asynchronously between edges with FIFOs non-empty -> cdb_valid=0 and fu_ready=0 immediately; after release no stale tag broadcasts.
- Wrap: rr=3, only FU3 and FU0 non-empty -> slot0=FU3 result, slot1=FU0 result, rr becomes 1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Result/broadcast bus of the CDB arbiter.
// The master side is the arbiter: it takes fu_* results in and drives fu_ready
// and the cdb_* broadcast. The slave side is the environment: execution units
// driving results and the reservation station snooping the CDB.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int PHYS_W = 6
);
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0]             fu_ready;
  logic [NUM_FU-1:0][PHYS_W-1:0] fu_tag;
  logic [NUM_FU-1:0][63:0]       fu_value;
  logic [NUM_FU-1:0][5:0]        fu_rob_tag;

  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]  cdb_tag;
  logic [CDB_W-1:0][63:0]        cdb_value;
  logic [CDB_W-1:0][5:0]         cdb_rob_tag;

  modport master (
    input  fu_valid, fu_tag, fu_value, fu_rob_tag,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

  modport slave (
    output fu_valid, fu_tag, fu_value, fu_rob_tag,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completed results from NUM_FU execution
// units in per-source FIFOs and broadcasts up to CDB_W of them per cycle,
// chosen round-robin, on registered CDB outputs.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int CDB_W      = 2,
  parameter int PHYS_W     = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  input  logic          flush,
  cdb_arbiter_if.master bus,
  output logic          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic [63:0]       value;
    logic [5:0]        rob_tag;
  } entry_t;

  entry_t           mem    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NUM_FU];
  logic [PTR_W-1:0] rd_ptr [NUM_FU];
  logic [CNT_W-1:0] count  [NUM_FU];

  logic [RR_W-1:0]   rr;
  logic [RR_W-1:0]   rr_next;
  logic [RR_W-1:0]   last_src;
  logic [NUM_FU-1:0] nonempty;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] grant;

  logic [CDB_W-1:0] slot_valid;
  logic [RR_W-1:0]  slot_src   [CDB_W];
  entry_t           slot_entry [CDB_W];

  logic [CDB_W-1:0] cdb_valid_q;
  entry_t           cdb_q [CDB_W];

  // Per-source status: ready comes from the registered count only, and is held
  // low while reset is asserted so sources cannot hand off into a dead FIFO.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      nonempty[i] = (count[i] != '0);
      ready[i]    = reset && (count[i] < CNT_W'(FIFO_DEPTH));
    end
  end

  // A handshake completes on valid & ready; a flush discards it.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = bus.fu_valid[i] && ready[i] && !flush;
    end
  end

  // Round-robin select: scan from rr, the k-th non-empty source found fills slot k.
  always_comb begin
    int n;
    // NOTE: every output of this block gets a default before the scan; a path
    // that leaves one unassigned would infer a latch.
    grant      = '0;
    slot_valid = '0;
    last_src   = rr;
    n          = 0;
    for (int k = 0; k < CDB_W; k++) begin
      slot_src[k] = '0;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (i == (int'(rr) + j) % NUM_FU && nonempty[i] && n < CDB_W) begin
          grant[i] = 1'b1;
          last_src = RR_W'(i);
          for (int k = 0; k < CDB_W; k++) begin
            if (k == n) begin
              slot_valid[k] = 1'b1;
              slot_src[k]   = RR_W'(i);
            end
          end
          n++;
        end
      end
    end
    rr_next = rr;
    if (|grant) begin
      rr_next = (int'(last_src) == NUM_FU - 1) ? '0 : last_src + RR_W'(1);
    end
  end

  // Head-of-FIFO entry for each granted slot.
  always_comb begin
    for (int k = 0; k < CDB_W; k++) begin
      slot_entry[k] = mem[slot_src[k]][rd_ptr[slot_src[k]]];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
      end
    end
  end

  // FIFO storage write.
  // NOTE: storage has no reset; an entry is only read once count says it was
  // written, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= entry_t'{bus.fu_tag[i], bus.fu_value[i], bus.fu_rob_tag[i]};
      end
    end
  end

  // Broadcast registers and round-robin pointer; empty slots carry zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr          <= '0;
      cdb_valid_q <= '0;
      for (int k = 0; k < CDB_W; k++) cdb_q[k] <= '0;
    end else if (flush) begin
      rr          <= '0;
      cdb_valid_q <= '0;
      for (int k = 0; k < CDB_W; k++) cdb_q[k] <= '0;
    end else begin
      rr          <= rr_next;
      cdb_valid_q <= slot_valid;
      for (int k = 0; k < CDB_W; k++) begin
        cdb_q[k] <= slot_valid[k] ? slot_entry[k] : '0;
      end
    end
  end

  // Drive the bus from the registered broadcast state.
  always_comb begin
    bus.fu_ready  = ready;
    bus.cdb_valid = cdb_valid_q;
    for (int k = 0; k < CDB_W; k++) begin
      bus.cdb_tag[k]     = cdb_q[k].tag;
      bus.cdb_value[k]   = cdb_q[k].value;
      bus.cdb_rob_tag[k] = cdb_q[k].rob_tag;
    end
  end

  assign busy = (|nonempty) || (|cdb_valid_q);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a queue-based reference model predicts
// each broadcast, pushes it into a scoreboard, and a monitor on the falling
// edge pops and compares against the CDB outputs.
module tb_cdb_arbiter;

  localparam int NUM_FU     = 4;
  localparam int CDB_W      = 2;
  localparam int PHYS_W     = 6;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic [63:0]       value;
    logic [5:0]        rob;
  } item_t;

  typedef struct packed {
    logic [31:0]                stamp;
    logic [CDB_W-1:0]           valid;
    logic [CDB_W-1:0][PHYS_W+69:0] slot;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .PHYS_W(PHYS_W)) bus ();

  cdb_arbiter #(
    .NUM_FU(NUM_FU), .CDB_W(CDB_W), .PHYS_W(PHYS_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  int    edge_cnt    = 0;
  bit    mon_en      = 1'b0;

  item_t src_q [NUM_FU][$];   // what each source still wants to hand off
  item_t mq    [NUM_FU][$];   // model of each result buffer
  rec_t  exp_q [$];           // scoreboard of expected broadcasts
  int    m_rr   = 0;
  bit    m_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input int t, input logic [63:0] v, input int r);
    item_t it;
    it.tag   = PHYS_W'(t);
    it.value = v;
    it.rob   = 6'(r);
    return it;
  endfunction

  task automatic offer(input int fu, input int t, input logic [63:0] v, input int r);
    src_q[fu].push_back(mk(t, v, r));
  endtask

  // One clock of stimulus: present source heads, check ready/busy, then let the
  // model take the edge. Called just after a falling edge; returns on the next.
  task automatic drive_cycle(input bit fl);
    logic [NUM_FU-1:0] ready_exp;
    logic [NUM_FU-1:0] acc;
    item_t             head [NUM_FU];
    rec_t              rec;
    int                n;
    int                rr0;
    int                s;
    bit                any;
    for (int i = 0; i < NUM_FU; i++) begin
      ready_exp[i] = (mq[i].size() < FIFO_DEPTH);
      head[i]      = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      bus.fu_valid[i]   = (src_q[i].size() > 0);
      bus.fu_tag[i]     = head[i].tag;
      bus.fu_value[i]   = head[i].value;
      bus.fu_rob_tag[i] = head[i].rob;
    end
    flush = fl;
    #1;
    check("fu_ready", 64'(bus.fu_ready), 64'(ready_exp));
    check("busy", 64'(busy), 64'(m_busy));
    @(posedge clk);
    acc = bus.fu_valid & ready_exp;
    for (int i = 0; i < NUM_FU; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    edge_cnt++;
    if (fl) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      m_rr   = 0;
      m_busy = 1'b0;
    end else begin
      rec       = '0;
      rec.stamp = 32'(edge_cnt);
      n         = 0;
      rr0       = m_rr;
      for (int j = 0; j < NUM_FU; j++) begin
        s = (rr0 + j) % NUM_FU;
        if (mq[s].size() > 0 && n < CDB_W) begin
          rec.valid[n] = 1'b1;
          rec.slot[n]  = mq[s].pop_front();
          n++;
          m_rr = (s + 1) % NUM_FU;
        end
      end
      if (n > 0) exp_q.push_back(rec);
      for (int i = 0; i < NUM_FU; i++) begin
        if (acc[i]) mq[i].push_back(head[i]);
      end
      any = (n > 0);
      for (int i = 0; i < NUM_FU; i++) begin
        if (mq[i].size() > 0) any = 1'b1;
      end
      m_busy = any;
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  function automatic int pending();
    int p;
    p = exp_q.size();
    for (int i = 0; i < NUM_FU; i++) p += src_q[i].size() + mq[i].size();
    return p;
  endfunction

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (pending() == 0 && !m_busy) break;
      drive_cycle(1'b0);
    end
    check("drain_pending", 64'(pending()), 64'd0);
  endtask

  // Monitor: compare the CDB against the scoreboard every falling edge.
  rec_t mrec;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mrec = '0;
        if (exp_q.size() > 0 && exp_q[0].stamp == 32'(edge_cnt)) mrec = exp_q.pop_front();
        check("cdb_valid", 64'(bus.cdb_valid), 64'(mrec.valid));
        for (int k = 0; k < CDB_W; k++) begin
          item_t e;
          e = mrec.slot[k];
          check($sformatf("cdb_tag[%0d]", k), 64'(bus.cdb_tag[k]), 64'(e.tag));
          check($sformatf("cdb_value[%0d]", k), bus.cdb_value[k], e.value);
          check($sformatf("cdb_rob_tag[%0d]", k), 64'(bus.cdb_rob_tag[k]), 64'(e.rob));
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    bus.fu_valid   = '0;
    bus.fu_tag     = '0;
    bus.fu_value   = '0;
    bus.fu_rob_tag = '0;

    // Reset values.
    #2 reset = 1'b0;
    #1;
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fu_ready", 64'(bus.fu_ready), 64'd0);
    for (int k = 0; k < CDB_W; k++) begin
      check("rst_cdb_tag", 64'(bus.cdb_tag[k]), 64'd0);
      check("rst_cdb_value", bus.cdb_value[k], 64'd0);
      check("rst_cdb_rob_tag", 64'(bus.cdb_rob_tag[k]), 64'd0);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("post_rst_fu_ready", 64'(bus.fu_ready), 64'hF);
    mon_en = 1'b1;
    @(negedge clk);

    // Single result: FU0 tag 10 value 8 rob 0.
    offer(0, 10, 64'd8, 0);
    repeat (4) drive_cycle(1'b0);

    // Fairness: all four sources push every cycle.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NUM_FU; i++) offer(i, 20 + i, 64'(100 * i + c), c);
    end
    drain();

    // Backpressure: FU1 pushes 5,6,7 back to back against full contention.
    offer(1, 11, 64'd5, 1);
    offer(1, 12, 64'd6, 2);
    offer(1, 13, 64'd7, 3);
    for (int r = 0; r < 2; r++) begin
      offer(0, 50 + r, 64'(500 + r), r);
      offer(2, 52 + r, 64'(520 + r), r);
      offer(3, 54 + r, 64'(540 + r), r);
    end
    drain();

    // Flush mid-stream, with a push attempted in the flush cycle.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM_FU; i++) offer(i, 40 + i, 64'(400 + 10 * i + r), r);
    end
    repeat (3) drive_cycle(1'b0);
    drive_cycle(1'b1);
    drain();

    // Reset asserted between edges with buffers occupied.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_FU; i++) offer(i, 60 + i, 64'(600 + r), r);
    end
    repeat (2) drive_cycle(1'b0);
    #2 reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_FU; i++) begin
      src_q[i].delete();
      mq[i].delete();
    end
    m_rr         = 0;
    m_busy       = 1'b0;
    bus.fu_valid = '0;
    #1;
    check("midrst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("midrst_fu_ready", 64'(bus.fu_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_release_ready", 64'(bus.fu_ready), 64'hF);
    @(negedge clk);
    repeat (3) drive_cycle(1'b0);

    // Wrap: bring rr to 3 with only FU3 and FU0 holding results.
    drive_cycle(1'b1);
    offer(0, 30, 64'd300, 0);
    offer(1, 31, 64'd301, 1);
    offer(2, 32, 64'd302, 2);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    offer(3, 33, 64'd303, 3);
    offer(0, 34, 64'd304, 4);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    drain();

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if ($urandom_range(1, 0) == 1 && src_q[i].size() < 3) begin
          offer(i, int'($urandom_range(63, 0)), {$urandom, $urandom}, int'($urandom_range(63, 0)));
        end
      end
      drive_cycle($urandom_range(39, 0) == 0);
    end
    drain();

    repeat (3) drive_cycle(1'b0);
    check("scoreboard_left", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
